// File: rtl/reg_bus_master.sv
// reg_bus_master: framed UART byte-stream command decoder that initiates register-bank reads/writes.
// Optional macro REG_BUS_WRITE_ACK_EN adds a status byte (0xA5 ok / 0xEE timeout) after write frames.
module reg_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       reg_write,
    output logic       reg_read,
    output logic [7:0] reg_index,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_timeout
);

    // state  | meaning
    // IDLE   | waiting for header byte (rw, LEN)
    // ADDR   | waiting for start index byte
    // WDATA  | receiving write bytes, one strobe the cycle after each
    // RDREQ  | reg_read high, reg_rdata captured into tx_data
    // RDSEND | read byte offered on tx stream until accepted
    // ACK    | write status byte offered on tx stream (REG_BUS_WRITE_ACK_EN)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_RDREQ  = 3'd3,
        S_RDSEND = 3'd4
`ifdef REG_BUS_WRITE_ACK_EN
        , S_ACK  = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             is_write;
    logic [5:0]       left;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout;
    logic             rx_acc;
    logic             tx_acc;
    state_t           done_dest;
    state_t           tmo_dest;

    assign rx_acc      = rx_valid & rx_ready;
    assign tx_acc      = tx_valid & tx_ready;
    assign busy        = (state != S_IDLE);
    assign err_timeout = timeout;

`ifdef REG_BUS_WRITE_ACK_EN
    assign done_dest = S_ACK;
    assign tmo_dest  = is_write ? S_ACK : S_IDLE;
`else
    assign done_dest = S_IDLE;
    assign tmo_dest  = S_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        reg_read  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_nxt = is_write ? S_WDATA : S_RDREQ;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = tmo_dest;
                end
            end
            S_WDATA: begin
                // Once all N bytes are in, stay one more cycle for the final strobe.
                rx_ready = (left != 6'd0);
                if (rx_valid && rx_ready) begin
                    state_nxt = S_WDATA;
                end else if (left == 6'd0) begin
                    state_nxt = done_dest;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = tmo_dest;
                end
            end
            S_RDREQ: begin
                reg_read  = 1'b1;
                state_nxt = S_RDSEND;
            end
            S_RDSEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_nxt = (left == 6'd1) ? S_IDLE : S_RDREQ;
                end
            end
`ifdef REG_BUS_WRITE_ACK_EN
            S_ACK: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            rx_ready = 1'b0;
            tx_valid = 1'b0;
            reg_read = 1'b0;
            timeout  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == S_ADDR || state == S_WDATA) && !rx_acc && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_write  <= 1'b0;
            left      <= 6'd0;
            reg_write <= 1'b0;
            reg_index <= 8'h00;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
        end else begin
            reg_write <= 1'b0;
            if (reg_write) begin
                reg_index <= reg_index + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_acc) begin
                        is_write <= rx_data[7];
                        left     <= {1'b0, rx_data[4:0]} + 6'd1;
                    end
                end
                S_ADDR: begin
                    if (rx_acc) begin
                        reg_index <= rx_data;
                    end
                end
                S_WDATA: begin
                    if (rx_acc) begin
                        reg_write <= 1'b1;
                        reg_wdata <= rx_data;
                        left      <= left - 6'd1;
                    end
                end
                S_RDREQ: begin
                    tx_data <= reg_rdata;
                end
                S_RDSEND: begin
                    if (tx_acc) begin
                        reg_index <= reg_index + 8'd1;
                        left      <= left - 6'd1;
                    end
                end
                default: begin
                end
            endcase
`ifdef REG_BUS_WRITE_ACK_EN
            if (state_nxt == S_ACK && state != S_ACK) begin
                tx_data <= timeout ? 8'hEE : 8'hA5;
            end
`endif
        end
    end

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst) !(reg_write && reg_read));

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: frame-level reference model with a register-bank fixture.
`timescale 1ns/1ps
module tb_reg_bus_master;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_index;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_timeout;

    always #5 clk = ~clk;

    reg_bus_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(24)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_write(reg_write), .reg_read(reg_read),
        .reg_index(reg_index), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .err_timeout(err_timeout)
    );

    // Register bank fixture (what the DUT talks to) and the bench's own expectation of its contents.
    logic [7:0] bank [256];
    logic [7:0] ref_mem [256];
    logic [7:0] wbuf [32];

    assign reg_rdata = bank[reg_index];
    always @(posedge clk) if (reg_write === 1'b1) bank[reg_index] <= reg_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int err_pulses = 0;
    logic [15:0] wq [$];
    int wt [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            wq.push_back({reg_index, reg_wdata});
            wt.push_back(cyc);
        end
        if (reg_read === 1'b1) rd_pulses++;
        if (err_timeout === 1'b1) err_pulses++;
        if (reg_write === 1'b1 || reg_read === 1'b1) begin
            total++;
            if (reg_write === 1'b1 && reg_read === 1'b1) begin
                bad++;
                $display("FAIL rw_overlap: reg_write=%b reg_read=%b, want not both 1", reg_write, reg_read);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            acc = (rx_ready === 1'b1);
            step();
            if (acc) break;
            n++;
        end
        rx_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL rx_accept: byte %02h not accepted after %0d cycles, want accepted", b, n);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 300) begin step(); w++; end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: busy=%b after %0d cycles, want 0", tag, busy, w);
        end
    endtask

    task automatic expect_tx(input logic [7:0] exp, input int stall, input string tag);
        int w;
        w = 0;
        while (tx_valid !== 1'b1 && w < 100) begin step(); w++; end
        total++;
        if (tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s tx_valid: got %b after %0d cycles, want 1", tag, tx_valid, w);
            return;
        end
        for (int s = 0; s < stall; s++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp || rx_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s stall: tx_valid=%b tx_data=%02h rx_ready=%b, want 1 %02h 0",
                         tag, tx_valid, tx_data, rx_ready, exp);
            end
            step();
        end
        total++;
        if (tx_data !== exp) begin
            bad++;
            $display("FAIL %s tx_data: got %02h, want %02h", tag, tx_data, exp);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] start, input int n, input bit b2b, input string tag);
        logic [7:0] hdr;
        int gap;
        wq.delete();
        wt.delete();
        hdr = {1'b1, 2'($urandom_range(0, 3)), 5'(n - 1)};
        send_byte(hdr);
        send_byte(start);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i]);
            if (!b2b) begin
                gap = $urandom_range(0, 3);
                repeat (gap) step();
            end
        end
`ifdef REG_BUS_WRITE_ACK_EN
        expect_tx(8'hA5, $urandom_range(0, 3), {tag, "_ack"});
`endif
        wait_idle(tag);
        total++;
        if (wq.size() != n) begin
            bad++;
            $display("FAIL %s strobe_count: got %0d, want %0d", tag, wq.size(), n);
        end
        for (int i = 0; i < n && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== {8'(start + i), wbuf[i]}) begin
                bad++;
                $display("FAIL %s strobe%0d: got idx/data %04h, want %02h%02h", tag, i, wq[i], 8'(start + i), wbuf[i]);
            end
            if (b2b && i > 0) begin
                total++;
                if (wt[i] - wt[i-1] != 1) begin
                    bad++;
                    $display("FAIL %s strobe_spacing%0d: got %0d cycles, want 1", tag, i, wt[i] - wt[i-1]);
                end
            end
        end
        for (int i = 0; i < n; i++) ref_mem[8'(start + i)] = wbuf[i];
    endtask

    task automatic do_read(input logic [7:0] start, input int n, input int max_stall, input string tag);
        int rd0;
        rd0 = rd_pulses;
        send_byte({1'b0, 2'($urandom_range(0, 3)), 5'(n - 1)});
        send_byte(start);
        for (int i = 0; i < n; i++) begin
            expect_tx(ref_mem[8'(start + i)], $urandom_range(0, max_stall), tag);
        end
        wait_idle(tag);
        total++;
        if (rd_pulses - rd0 != n) begin
            bad++;
            $display("FAIL %s read_pulses: got %0d, want %0d", tag, rd_pulses - rd0, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        repeat (3) step();
        total++;
        if ({rx_ready, tx_valid, tx_data, reg_write, reg_read, reg_index, reg_wdata, busy, err_timeout} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rx_ready=%b tx_valid=%b tx_data=%02h wr=%b rd=%b idx=%02h wd=%02h busy=%b err=%b, want all 0",
                     rx_ready, tx_valid, tx_data, reg_write, reg_read, reg_index, reg_wdata, busy, err_timeout);
        end
        rst = 1'b0;
        step();
        total++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rx_ready=%b busy=%b, want 1 0", rx_ready, busy);
        end
    endtask

    task automatic test_write_single();
        wbuf[0] = 8'h37;
        do_write(8'h02, 1, 1'b1, "write_single");
    endtask

    task automatic test_back_to_back();
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wbuf[2] = 8'h33;
        do_write(8'hFF, 3, 1'b1, "burst_wrap");
    endtask

    task automatic test_fill();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 32; i++) wbuf[i] = 8'($urandom);
            do_write(8'(f * 32), 32, f[0], "fill");
        end
    endtask

    task automatic test_read_backpressure();
        int rd0;
        wbuf[0] = 8'hAB;
        wbuf[1] = 8'hCD;
        do_write(8'h04, 2, 1'b1, "read_setup");
        rd0 = rd_pulses;
        send_byte(8'h01);
        send_byte(8'h04);
        expect_tx(8'hAB, 5, "read_bp0");
        expect_tx(8'hCD, 5, "read_bp1");
        wait_idle("read_bp");
        total++;
        if (rd_pulses - rd0 != 2) begin
            bad++;
            $display("FAIL read_bp pulses: got %0d, want 2", rd_pulses - rd0);
        end
    endtask

    task automatic test_timeout();
        int e0;
        int seen;
        e0 = err_pulses;
        seen = 0;
        wq.delete();
        send_byte(8'h81);
        send_byte(8'h10);
        send_byte(8'h55);
        for (int k = 1; k <= 3 * TMO; k++) begin
            if (err_timeout === 1'b1) begin seen = k; break; end
            step();
        end
        total++;
        if (seen != TMO) begin
            bad++;
            $display("FAIL timeout_delay: err_timeout in cycle %0d, want %0d", seen, TMO);
        end
        step();
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width: err_timeout=%b one cycle later, want 0", err_timeout);
        end
`ifdef REG_BUS_WRITE_ACK_EN
        expect_tx(8'hEE, 2, "timeout_errbyte");
`endif
        wait_idle("timeout");
        total++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== 16'h1055)) begin
            bad++;
            $display("FAIL timeout_strobes: got %0d strobes (first %04h), want 1 strobe 1055",
                     wq.size(), (wq.size() > 0) ? wq[0] : 16'h0000);
        end
        ref_mem[8'h10] = 8'h55;
        total++;
        if (err_pulses - e0 != 1) begin
            bad++;
            $display("FAIL timeout_count: got %0d pulses, want 1", err_pulses - e0);
        end
        wbuf[0] = 8'h9C;
        wbuf[1] = 8'h3E;
        do_write(8'h10, 2, 1'b1, "after_timeout");
        do_read(8'h0F, 4, 2, "after_timeout_rd");
    endtask

    task automatic test_timeout_addr();
        int seen;
        int rd0;
        seen = 0;
        rd0 = rd_pulses;
        send_byte(8'h03);
        for (int k = 1; k <= 3 * TMO; k++) begin
            if (err_timeout === 1'b1) begin seen = k; break; end
            step();
        end
        total++;
        if (seen != TMO) begin
            bad++;
            $display("FAIL timeout_addr_delay: err_timeout in cycle %0d, want %0d", seen, TMO);
        end
        wait_idle("timeout_addr");
        total++;
        if (rd_pulses != rd0) begin
            bad++;
            $display("FAIL timeout_addr_reads: got %0d reads, want 0", rd_pulses - rd0);
        end
    endtask

    task automatic test_byte_wins();
        int e0;
        e0 = err_pulses;
        wq.delete();
        wbuf[0] = 8'($urandom);
        wbuf[1] = 8'($urandom);
        send_byte(8'h81);
        send_byte(8'h20);
        repeat (TMO - 1) step();
        send_byte(wbuf[0]);
        repeat (TMO - 1) step();
        send_byte(wbuf[1]);
`ifdef REG_BUS_WRITE_ACK_EN
        expect_tx(8'hA5, 0, "byte_wins_ack");
`endif
        wait_idle("byte_wins");
        total++;
        if (err_pulses != e0) begin
            bad++;
            $display("FAIL byte_wins_err: got %0d timeout pulses, want 0", err_pulses - e0);
        end
        total++;
        if (wq.size() != 2 || (wq.size() == 2 && (wq[0] !== {8'h20, wbuf[0]} || wq[1] !== {8'h21, wbuf[1]}))) begin
            bad++;
            $display("FAIL byte_wins_strobes: got %0d strobes, want 2 at 20/21", wq.size());
        end
        ref_mem[8'h20] = wbuf[0];
        ref_mem[8'h21] = wbuf[1];
    endtask

    task automatic test_reset_mid_read();
        int w;
        int rd0;
        w = 0;
        send_byte(8'h03);
        send_byte(8'h40);
        while (tx_valid !== 1'b1 && w < 50) begin step(); w++; end
        total++;
        if (tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_read tx_valid: got %b, want 1", tx_valid);
        end
        rd0 = rd_pulses;
        rst = 1'b1;
        step();
        total++;
        if ({rx_ready, tx_valid, tx_data, reg_write, reg_read, reg_index, reg_wdata, busy, err_timeout} !== 30'd0) begin
            bad++;
            $display("FAIL rst_mid_read outputs: got rx_ready=%b tx_valid=%b tx_data=%02h wr=%b rd=%b idx=%02h wd=%02h busy=%b err=%b, want all 0",
                     rx_ready, tx_valid, tx_data, reg_write, reg_read, reg_index, reg_wdata, busy, err_timeout);
        end
        step();
        rst = 1'b0;
        repeat (10) step();
        total++;
        if (rd_pulses != rd0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_read after: got reads=%0d tx_valid=%b busy=%b, want 0 0 0", rd_pulses - rd0, tx_valid, busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] start;
        int n;
        for (int it = 0; it < 24; it++) begin
            start = (it % 6 == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
            n = (it % 8 == 3) ? 32 : $urandom_range(1, 32);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(start, n, $urandom_range(0, 1) == 1, "rand_write");
            end else begin
                do_read(start, n, 3, "rand_read");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_back_to_back();
        test_fill();
        test_read_backpressure();
        test_timeout();
        test_timeout_addr();
        test_byte_wins();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
